// File: rtl/phase_to_amplitude.sv
// phase_to_amplitude: 3-stage phase-to-amplitude converter for a DDS.
// Turns an 8-bit phase into an 8-bit offset-binary sample (midscale 128)
// for a sine, triangle, sawtooth or square wave, with a power-of-two
// attenuation applied around midscale.
//
// Ports
//   clk        in   1  rising-edge clock for all state
//   reset      in   1  asynchronous active-high reset
//   en         in   1  pipeline advance enable (0 = every register holds)
//   in_valid   in   1  phase_in carries a sample this cycle
//   phase_in   in   8  unsigned phase, 256 steps per period
//   wave_sel   in   2  00 sine, 01 triangle, 10 sawtooth, 11 square
//   atten      in   3  attenuation as an arithmetic right-shift count
//   out_valid  out  1  amp_out holds a new sample
//   amp_out    out  8  offset-binary amplitude, held while out_valid=0
module phase_to_amplitude (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       in_valid,
    input  logic [7:0] phase_in,
    input  logic [1:0] wave_sel,
    input  logic [2:0] atten,
    output logic       out_valid,
    output logic [7:0] amp_out
);

    localparam int unsigned PHASE_W = 8;
    localparam int unsigned AMP_W   = 8;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned ATT_W   = 3;
    localparam int unsigned LUT_W   = 7;
    localparam int unsigned IDX_W   = 6;

    localparam logic [SEL_W-1:0] SEL_SINE = 2'b00;
    localparam logic [SEL_W-1:0] SEL_TRI  = 2'b01;
    localparam logic [SEL_W-1:0] SEL_SAW  = 2'b10;
    localparam logic [SEL_W-1:0] SEL_SQR  = 2'b11;

    localparam logic [AMP_W-1:0] MIDSCALE = 8'd128;

    // Quarter-wave sine table sampled at half-step offsets, amplitude 127.
    function automatic logic [LUT_W-1:0] f_lut(input logic [IDX_W-1:0] idx);
        logic [LUT_W-1:0] v;
        v = 7'd0;
        case (idx)
            6'd0:  v = 7'd2;    6'd1:  v = 7'd5;    6'd2:  v = 7'd8;    6'd3:  v = 7'd11;
            6'd4:  v = 7'd14;   6'd5:  v = 7'd17;   6'd6:  v = 7'd20;   6'd7:  v = 7'd23;
            6'd8:  v = 7'd26;   6'd9:  v = 7'd29;   6'd10: v = 7'd32;   6'd11: v = 7'd35;
            6'd12: v = 7'd38;   6'd13: v = 7'd41;   6'd14: v = 7'd44;   6'd15: v = 7'd47;
            6'd16: v = 7'd50;   6'd17: v = 7'd53;   6'd18: v = 7'd56;   6'd19: v = 7'd58;
            6'd20: v = 7'd61;   6'd21: v = 7'd64;   6'd22: v = 7'd67;   6'd23: v = 7'd69;
            6'd24: v = 7'd72;   6'd25: v = 7'd74;   6'd26: v = 7'd77;   6'd27: v = 7'd79;
            6'd28: v = 7'd82;   6'd29: v = 7'd84;   6'd30: v = 7'd86;   6'd31: v = 7'd89;
            6'd32: v = 7'd91;   6'd33: v = 7'd93;   6'd34: v = 7'd95;   6'd35: v = 7'd97;
            6'd36: v = 7'd99;   6'd37: v = 7'd101;  6'd38: v = 7'd103;  6'd39: v = 7'd105;
            6'd40: v = 7'd106;  6'd41: v = 7'd108;  6'd42: v = 7'd110;  6'd43: v = 7'd111;
            6'd44: v = 7'd113;  6'd45: v = 7'd114;  6'd46: v = 7'd115;  6'd47: v = 7'd117;
            6'd48: v = 7'd118;  6'd49: v = 7'd119;  6'd50: v = 7'd120;  6'd51: v = 7'd121;
            6'd52: v = 7'd122;  6'd53: v = 7'd123;  6'd54: v = 7'd124;  6'd55: v = 7'd124;
            6'd56: v = 7'd125;  6'd57: v = 7'd125;  6'd58: v = 7'd126;  6'd59: v = 7'd126;
            6'd60: v = 7'd127;  6'd61: v = 7'd127;  6'd62: v = 7'd127;  6'd63: v = 7'd127;
        endcase
        return v;
    endfunction

    // Stage 1: captured sample and its own settings
    logic               r_s1_valid;
    logic [PHASE_W-1:0] r_s1_phase;
    logic [SEL_W-1:0]   r_s1_sel;
    logic [ATT_W-1:0]   r_s1_atten;

    // Stage 2: raw waveform value
    logic               r_s2_valid;
    logic [AMP_W-1:0]   r_s2_raw;
    logic [ATT_W-1:0]   r_s2_atten;

    // Stage 3: attenuated output
    logic               r_out_valid;
    logic [AMP_W-1:0]   r_amp;

    logic [IDX_W-1:0]   w_idx;
    logic [LUT_W-1:0]   w_lut;
    logic [AMP_W-1:0]   w_tri;
    logic [AMP_W-1:0]   w_raw;
    logic signed [8:0]  w_c;
    logic signed [8:0]  w_shift;
    logic [AMP_W-1:0]   w_amp;

    // Raw waveform from the stage-1 phase; odd quadrants read the table mirrored (63-i == ~i).
    always_comb begin
        w_idx = r_s1_phase[6] ? ~r_s1_phase[5:0] : r_s1_phase[5:0];
        w_lut = f_lut(w_idx);
        w_tri = {r_s1_phase[6:0], 1'b0};
        w_raw = '0;
        case (r_s1_sel)
            SEL_SINE: w_raw = r_s1_phase[7] ? (8'd127 - {1'b0, w_lut})
                                            : (MIDSCALE + {1'b0, w_lut});
            SEL_TRI:  w_raw = r_s1_phase[7] ? ~w_tri : w_tri;
            SEL_SAW:  w_raw = r_s1_phase;
            SEL_SQR:  w_raw = r_s1_phase[7] ? 8'd0 : 8'd255;
        endcase
    end

    // Attenuation about midscale; the shifted value stays in -128..127, so the
    // re-offset fits 8 bits and can be done modulo 256.
    always_comb begin
        w_c     = $signed({1'b0, r_s2_raw}) - 9'sd128;
        w_shift = w_c >>> r_s2_atten;
        w_amp   = 8'(w_shift) + MIDSCALE;
    end

    // Pipeline registers: valids always advance with en, data only behind a valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_phase  <= '0;
            r_s1_sel    <= '0;
            r_s1_atten  <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_raw    <= '0;
            r_s2_atten  <= '0;
            r_out_valid <= 1'b0;
            r_amp       <= MIDSCALE;
        end else if (en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_phase <= phase_in;
                r_s1_sel   <= wave_sel;
                r_s1_atten <= atten;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_raw   <= w_raw;
                r_s2_atten <= r_s1_atten;
            end
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_amp <= w_amp;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign amp_out   = r_amp;

endmodule
